// File: rtl/ins_fetch_seq.sv
// ins_fetch_seq
//   Multi-cycle instruction fetch/decode sequencer. Fetches a 32-bit word over a
//   req/ack handshake, splits it into RV32 fields, presents the bundle over a
//   valid/ready handshake, then advances the PC (+4 or redirect) and counts
//   retired instructions. Timeouts and misaligned redirects park the block in a
//   sticky FAULT state that only reset clears.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   enable_i                 run control, sampled in IDLE and on the issue handshake
//   imem_req_o/addr_o        fetch request and address (address is the current PC)
//   imem_ack_i/rdata_i       memory response; rdata captured on the ack edge
//   out_valid_o/out_ready_i  decoded bundle handshake
//   instr_o, pc_out_o        raw word and PC of the issued instruction
//   opcode_o..funct7_o       RV32 field split of instr
//   redirect_valid_i/pc_i    next-PC override, used only on the handshake edge
//   ins_count_o              retired instruction count (wraps at 2^32)
//   fault_o, fault_code_o    sticky fault: 01 fetch timeout, 10 misaligned redirect
module ins_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_out_o,
    output logic [6:0]  opcode_o,
    output logic [4:0]  rd_o,
    output logic [2:0]  funct3_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [6:0]  funct7_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ins_count_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_FAULT
    } state_e;

    localparam logic [1:0] FC_TIMEOUT   = 2'b01;
    localparam logic [1:0] FC_MISALIGN  = 2'b10;
    // The timeout fires on the edge where the counter would reach MAX_WAIT.
    localparam logic [7:0] WAIT_LAST    = 8'(MAX_WAIT - 1);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [7:0]  wait_q;
    logic        imem_req_q;
    logic        out_valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;
    logic [6:0]  opcode_q;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [6:0]  funct7_q;
    logic [31:0] ins_count_q;
    logic        fault_q;
    logic [1:0]  fault_code_q;

    logic        handshake_d;
    logic        redirect_bad_d;
    logic [31:0] next_pc_d;

    always_comb begin
        handshake_d    = out_valid_q & out_ready_i;
        redirect_bad_d = redirect_valid_i & (redirect_pc_i[1:0] != 2'b00);
        next_pc_d      = redirect_valid_i ? redirect_pc_i : pc_q + 32'd4;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            wait_q       <= '0;
            imem_req_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            instr_q      <= '0;
            pc_out_q     <= '0;
            opcode_q     <= '0;
            rd_q         <= '0;
            funct3_q     <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            funct7_q     <= '0;
            ins_count_q  <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                        wait_q     <= '0;
                    end
                end

                S_FETCH: begin
                    if (imem_ack_i) begin
                        instr_q    <= imem_rdata_i;
                        wait_q     <= '0;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        wait_q       <= wait_q + 8'd1;
                        imem_req_q   <= 1'b0;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_TIMEOUT;
                        state_q      <= S_FAULT;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end

                S_DECODE: begin
                    opcode_q    <= instr_q[6:0];
                    rd_q        <= instr_q[11:7];
                    funct3_q    <= instr_q[14:12];
                    rs1_q       <= instr_q[19:15];
                    rs2_q       <= instr_q[24:20];
                    funct7_q    <= instr_q[31:25];
                    pc_out_q    <= pc_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (handshake_d) begin
                        out_valid_q <= 1'b0;
                        ins_count_q <= ins_count_q + 32'd1;
                        if (redirect_bad_d) begin
                            // Misaligned target: retire the instruction but keep pc.
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_MISALIGN;
                            state_q      <= S_FAULT;
                        end else begin
                            pc_q <= next_pc_d;
                            if (enable_i) begin
                                state_q    <= S_FETCH;
                                imem_req_q <= 1'b1;
                                wait_q     <= '0;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                end

                S_FAULT: begin
                    // Parked until reset.
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_req_o   = imem_req_q;
    assign imem_addr_o  = pc_q;
    assign out_valid_o  = out_valid_q;
    assign instr_o      = instr_q;
    assign pc_out_o     = pc_out_q;
    assign opcode_o     = opcode_q;
    assign rd_o         = rd_q;
    assign funct3_o     = funct3_q;
    assign rs1_o        = rs1_q;
    assign rs2_o        = rs2_q;
    assign funct7_o     = funct7_q;
    assign ins_count_o  = ins_count_q;
    assign fault_o      = fault_q;
    assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_ins_fetch_seq.sv
// Directed bench for ins_fetch_seq: a small memory driver pushes the expected
// bundle into a scoreboard queue on every ack, and the issue side pops it and
// compares the decoded outputs. A second instance with RESET_PC = 32'hFFFF_FFFC
// covers PC wrap.
module tb_ins_fetch_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0, MAX_WAIT = 3)
    logic        rst_n, enable, imem_ack, out_ready, redirect_valid;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, out_valid, fault;
    logic [31:0] imem_addr, instr, pc_out, ins_count;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [1:0]  fault_code;

    // Wrap instance (RESET_PC = FFFF_FFFC)
    logic        w_rst_n, w_enable, w_ack, w_ready, w_redir;
    logic [31:0] w_rdata;
    logic        w_req, w_valid, w_fault;
    logic [31:0] w_addr, w_instr, w_pc_out, w_count;
    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic [1:0]  w_fault_code;

    ins_fetch_seq #(.RESET_PC(32'h0000_0000), .MAX_WAIT(3)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .instr_o(instr), .pc_out_o(pc_out),
        .opcode_o(opcode), .rd_o(rd), .funct3_o(funct3),
        .rs1_o(rs1), .rs2_o(rs2), .funct7_o(funct7),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .ins_count_o(ins_count), .fault_o(fault), .fault_code_o(fault_code)
    );

    ins_fetch_seq #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(15)) u_wrap (
        .clk_i(clk), .rst_ni(w_rst_n), .enable_i(w_enable),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_ack_i(w_ack), .imem_rdata_i(w_rdata),
        .out_valid_o(w_valid), .out_ready_i(w_ready),
        .instr_o(w_instr), .pc_out_o(w_pc_out),
        .opcode_o(w_opcode), .rd_o(w_rd), .funct3_o(w_funct3),
        .rs1_o(w_rs1), .rs2_o(w_rs2), .funct7_o(w_funct7),
        .redirect_valid_i(w_redir), .redirect_pc_i(redirect_pc),
        .ins_count_o(w_count), .fault_o(w_fault), .fault_code_o(w_fault_code)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int unsigned n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
    endtask

    // Serve one fetch: check address, ack after ack_delay cycles, push expectation.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data, input int ack_delay);
        exp_t e;
        wait_req();
        check("imem_addr", imem_addr, exp_addr);
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            check("req_hold", 32'(imem_req), 32'd1);
            check("addr_hold", imem_addr, exp_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        e.word = data;
        e.pc   = exp_addr;
        sb.push_back(e);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("valid_after_A", 32'(out_valid), 32'd0);
        check("req_drop", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("valid_after_A1", 32'(out_valid), 32'd1);
    endtask

    task automatic check_bundle(input exp_t e);
        logic [31:0] w;
        w = e.word;
        check("out_valid", 32'(out_valid), 32'd1);
        check("instr", instr, w);
        check("pc_out", pc_out, e.pc);
        check("opcode", 32'(opcode), 32'(w[6:0]));
        check("rd", 32'(rd), 32'(w[11:7]));
        check("funct3", 32'(funct3), 32'(w[14:12]));
        check("rs1", 32'(rs1), 32'(w[19:15]));
        check("rs2", 32'(rs2), 32'(w[24:20]));
        check("funct7", 32'(funct7), 32'(w[31:25]));
        check("count_hold", ins_count, exp_count);
    endtask

    // Pop the expected bundle, hold ready low for `stall` cycles, then handshake.
    task automatic collect(input int stall, input logic rv, input logic [31:0] rpc);
        exp_t e;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int i = 0; i <= stall; i++) begin
            check_bundle(e);
            if (i < stall) @(negedge clk);
        end
        out_ready      = 1'b1;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        exp_count++;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("ins_count", ins_count, exp_count);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        w_rst_n = 1'b0; w_enable = 1'b0; w_ack = 1'b0; w_rdata = '0;
        w_ready = 1'b0; w_redir = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", ins_count, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_code", 32'(fault_code), 32'd0);
        check("rst_instr", instr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_req", 32'(imem_req), 32'd0);
        enable = 1'b1;

        // Basic fetch/decode/issue
        fetch(32'h0, 32'hFE0F8F80, 1);
        check("tp_funct7", 32'(funct7), 32'd127);
        check("tp_rs1", 32'(rs1), 32'd31);
        check("tp_rd", 32'(rd), 32'd31);
        collect(0, 1'b0, 32'h0);
        check("next_addr_4", imem_addr, 32'h4);

        // Stall in ISSUE for 5 cycles
        fetch(32'h4, 32'h00A3_0313, 0);
        collect(5, 1'b0, 32'h0);
        check("next_addr_8", imem_addr, 32'h8);

        // Aligned redirect
        fetch(32'h8, 32'h1234_5678, 0);
        collect(0, 1'b1, 32'h0000_0100);
        check("redir_addr", imem_addr, 32'h100);

        // Misaligned redirect -> fault 10, pc unchanged
        fetch(32'h100, $urandom, 0);
        collect(0, 1'b1, 32'h0000_0102);
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_code", 32'(fault_code), 32'd2);
        check("mis_req", 32'(imem_req), 32'd0);
        check("mis_pc", imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fault_park_req", 32'(imem_req), 32'd0);
            check("fault_park_valid", 32'(out_valid), 32'd0);
            check("fault_park_code", 32'(fault_code), 32'd2);
        end

        // Reset clears fault
        rst_n = 1'b0;
        #1;
        check("clr_fault", 32'(fault), 32'd0);
        check("clr_code", 32'(fault_code), 32'd0);
        check("clr_addr", imem_addr, 32'h0);
        check("clr_count", ins_count, 32'd0);
        exp_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_no_req", 32'(imem_req), 32'd0);

        // Fetch timeout with MAX_WAIT = 3
        @(negedge clk);
        wait_req();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("to_req_high", 32'(imem_req), 32'd1);
        end
        @(negedge clk);
        check("to_req_low", 32'(imem_req), 32'd0);
        check("to_fault", 32'(fault), 32'd1);
        check("to_code", 32'(fault_code), 32'd1);
        rst_n = 1'b0;
        #1;
        check("to_clr_fault", 32'(fault), 32'd0);
        check("to_clr_pc", imem_addr, 32'h0);
        @(negedge clk);

        // Reset during FETCH
        rst_n = 1'b1;
        @(negedge clk);
        wait_req();
        rst_n = 1'b0;
        #1;
        check("rf_req", 32'(imem_req), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rf_idle_req", 32'(imem_req), 32'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("rf_resume_req", 32'(imem_req), 32'd1);

        // Reset during ISSUE
        fetch(32'h0, 32'hDEAD_BEEF, 0);
        rst_n = 1'b0;
        #1;
        check("ri_valid", 32'(out_valid), 32'd0);
        check("ri_instr", instr, 32'd0);
        check("ri_opcode", 32'(opcode), 32'd0);
        check("ri_pc_out", pc_out, 32'd0);
        void'(sb.pop_front());
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ri_idle_req", 32'(imem_req), 32'd0);
        enable = 1'b1;
        fetch(32'h0, 32'h0041_0093, 0);
        collect(0, 1'b0, 32'h0);
        check("ri_next_addr", imem_addr, 32'h4);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // PC wrap on the second instance
        w_rst_n = 1'b1;
        w_enable = 1'b1;
        begin
            int unsigned n = 0;
            @(negedge clk);
            while (w_req !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("w_req", 32'(w_req), 32'd1);
        check("w_addr", w_addr, 32'hFFFF_FFFC);
        w_ack = 1'b1;
        w_rdata = 32'h0000_0013;
        @(negedge clk);
        w_ack = 1'b0;
        @(negedge clk);
        check("w_valid", 32'(w_valid), 32'd1);
        check("w_pc_out", w_pc_out, 32'hFFFF_FFFC);
        check("w_instr", w_instr, 32'h0000_0013);
        w_ready = 1'b1;
        @(negedge clk);
        w_ready = 1'b0;
        check("w_wrap_addr", w_addr, 32'h0);
        check("w_count", w_count, 32'd1);
        check("w_valid_drop", 32'(w_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ins_fetch_seq.md
Name:
ins_fetch_seq

Overview:
- Multi-cycle instruction fetch/decode sequencer that drives the instruction-field parsing datapath.
- Requests a 32-bit word from instruction memory over a req/ack handshake, then splits it into RV32 fields (opcode, rd, funct3, rs1, rs2, funct7).
- Presents the decoded bundle to the downstream execute stage over a valid/ready handshake.
- Advances the PC by +4 or takes a redirect from execute, and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, maximum FETCH cycles without imem_ack before a timeout fault (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run control; sampled in IDLE and at the end of ISSUE.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  32  fetch address (current PC).
- imem_ack  in  1  memory response valid; imem_rdata captured in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- instr  out  32  raw instruction word.
- pc_out  out  32  PC of the issued instruction.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct7  out  7  instr[31:25].
- redirect_valid  in  1  next PC comes from redirect_pc; sampled only on the issue handshake cycle.
- redirect_pc  in  32  redirect target.
- ins_count  out  32  number of retired (handshaken) instructions.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 fetch timeout, 10 misaligned redirect.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, pc = RESET_PC, wait counter = 0.
  - All outputs 0, except imem_addr = RESET_PC.
  - A reset mid-transaction abandons it; no imem_req is issued on the cycle after release.
- States: IDLE, FETCH, DECODE, ISSUE, FAULT. All outputs are registered.
- IDLE:
  - enable = 1 moves to FETCH on the next edge; otherwise stay.
  - imem_req = 0, out_valid = 0.
- FETCH:
  - imem_req = 1 and imem_addr = pc, both stable until ack.
  - On an edge with imem_ack = 1: instr <= imem_rdata, wait counter cleared, move to DECODE.
  - Otherwise the wait counter increments. When the counter would reach MAX_WAIT, move to FAULT with fault_code = 01.
  - Deasserting enable in FETCH does not abort the fetch.
- DECODE (exactly 1 cycle):
  - Field outputs load from instr; pc_out <= pc.
  - Move to ISSUE.
- ISSUE:
  - out_valid = 1; instr, pc_out and all fields held stable while out_ready = 0. There is no timeout.
  - On an edge with out_valid & out_ready:
    - ins_count increments, wrapping at 2^32.
    - If redirect_valid = 1 and redirect_pc[1:0] != 0: move to FAULT with fault_code = 10; pc unchanged.
    - Else if redirect_valid = 1: pc <= redirect_pc.
    - Else: pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
    - If no fault: move to FETCH when enable = 1, otherwise IDLE.
  - out_valid drops on the cycle after the handshake.
- FAULT:
  - fault = 1 and fault_code held; imem_req = 0, out_valid = 0.
  - Exited only by reset.
- Latency:
  - IDLE with enable at edge E gives imem_req high after E.
  - ack sampled at edge A gives out_valid high after edge A+1.
  - Minimum 3 cycles per instruction with zero-wait memory and out_ready tied high.
- redirect_valid and redirect_pc are ignored outside the handshake cycle.

Test Plan:
- Reset, enable = 1, ack one cycle after req, imem_rdata = 32'hFE0F8F80, out_ready = 1 -> imem_addr = 0; out_valid two edges after ack with funct7 = 127, rs2 = 0, rs1 = 31, funct3 = 0, rd = 31, opcode = 0, pc_out = 0; next imem_addr = 4; ins_count = 1.
- out_ready held low 5 cycles in ISSUE, then high -> out_valid and all fields stable for 6 cycles; exactly one count increment; next fetch address = pc + 4.
- Redirect on handshake with redirect_pc = 32'h0000_0100 -> next imem_addr = 0x100. Repeat with redirect_pc = 32'h0000_0102 -> fault = 1, fault_code = 10, imem_req stays 0.
- MAX_WAIT = 3, imem_ack never asserted -> imem_req high for 3 cycles, then fault = 1, fault_code = 01. Asserting reset clears fault and returns pc to RESET_PC.
- RESET_PC = 32'hFFFF_FFFC, one instruction retired -> next imem_addr = 0 (wrap).
- Assert reset during FETCH and during ISSUE -> outputs go to 0 immediately (asynchronous); after release, no imem_req until IDLE samples enable.
